// File: rtl/mdu_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
package mdu_pkg;

  localparam logic [6:0] Funct7Mdu = 7'b0000001;

  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StFin
  } mdu_state_e;

  // MUL only needs the low half, which is the same whether treated signed or not.
  function automatic logic op_signed_a(mdu_op_e op);
    return op inside {OpMul, OpMulh, OpMulhsu, OpDiv, OpRem};
  endfunction

  function automatic logic op_signed_b(mdu_op_e op);
    return op inside {OpMul, OpMulh, OpDiv, OpRem};
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negation; maps magnitude <-> signed value.
module mdu_sign_fix #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] mag_i,
  input  logic             neg_i,
  output logic [Width-1:0] val_o
);

  always_comb begin
    val_o = neg_i ? (~mag_i + Width'(1)) : mag_i;
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit with start/busy/done handshake and flush.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned FAST_MUL = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned    CntW   = $clog2(XLEN);
  localparam logic [CntW-1:0] CntMax = CntW'(XLEN - 1);
  localparam logic [XLEN-1:0] IntMin = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e        state_q, state_d;
  mdu_op_e           op_q, op_d;
  logic              neg_p_q, neg_p_d, neg_q_q, neg_q_d, neg_r_q, neg_r_d;
  logic              fast_q, fast_d, done_q, done_d;
  logic [XLEN-1:0]   mcand_q, mcand_d, result_q, result_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  // Operand capture path
  mdu_op_e         op_in;
  logic            sa, sb, b_zero, ovf;
  logic [XLEN-1:0] mag_a, mag_b;

  assign op_in  = mdu_op_e'(funct3);
  assign sa     = op_signed_a(op_in) & a[XLEN-1];
  assign sb     = op_signed_b(op_in) & b[XLEN-1];
  assign b_zero = (b == '0);
  assign ovf    = (op_in == OpDiv || op_in == OpRem) && (a == IntMin) && (b == '1);

  mdu_sign_fix #(.Width(XLEN)) u_fix_a (.mag_i(a), .neg_i(sa), .val_o(mag_a));
  mdu_sign_fix #(.Width(XLEN)) u_fix_b (.mag_i(b), .neg_i(sb), .val_o(mag_b));

  // One iteration step; acc holds {hi, multiplier} or {remainder, dividend/quotient}.
  logic [XLEN:0]     mul_sum, div_sh, div_sub;
  logic              div_ge;
  logic [2*XLEN-1:0] prod_full, acc_step;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    div_sh    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge    = (div_sh >= {1'b0, mcand_q});
    div_sub   = div_sh - {1'b0, mcand_q};
    prod_full = {{XLEN{1'b0}}, mcand_q} * {{XLEN{1'b0}}, acc_q[XLEN-1:0]};
    acc_step  = acc_q;
    if (state_q == StMul) begin
      acc_step = (FAST_MUL != 0) ? prod_full : {mul_sum, acc_q[XLEN-1:1]};
    end else if (state_q == StDiv && !fast_q) begin
      acc_step = {(div_ge ? div_sub[XLEN-1:0] : div_sh[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
    end
  end

  // Sign correction of the finished magnitudes
  logic [2*XLEN-1:0] prod_val;
  logic [XLEN-1:0]   quo_val, rem_val, sel_val;

  mdu_sign_fix #(.Width(2*XLEN)) u_fix_p (.mag_i(acc_step), .neg_i(neg_p_q), .val_o(prod_val));
  mdu_sign_fix #(.Width(XLEN)) u_fix_q (
    .mag_i(acc_step[XLEN-1:0]), .neg_i(neg_q_q), .val_o(quo_val)
  );
  mdu_sign_fix #(.Width(XLEN)) u_fix_r (
    .mag_i(acc_step[2*XLEN-1:XLEN]), .neg_i(neg_r_q), .val_o(rem_val)
  );

  always_comb begin
    unique case (op_q)
      OpMul:                     sel_val = prod_val[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: sel_val = prod_val[2*XLEN-1:XLEN];
      OpDiv, OpDivu:             sel_val = quo_val;
      default:                   sel_val = rem_val;
    endcase
  end

  logic last;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_p_d  = neg_p_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    fast_d   = fast_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    last     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !flush) begin
          op_d    = op_in;
          neg_p_d = sa ^ sb;
          // Divide-by-zero quotient is all ones regardless of operand signs
          neg_q_d = (sa ^ sb) & ~b_zero;
          neg_r_d = sa;
          fast_d  = funct3[2] & (b_zero | ovf);
          cnt_d   = '0;
          if (funct3[2]) begin
            mcand_d = mag_b;
            acc_d   = b_zero ? {mag_a, {XLEN{1'b1}}} : {{XLEN{1'b0}}, mag_a};
            state_d = StDiv;
          end else begin
            mcand_d = mag_a;
            acc_d   = {{XLEN{1'b0}}, mag_b};
            state_d = StMul;
          end
        end
      end
      StMul: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CntW'(1);
        last  = (FAST_MUL != 0) || (cnt_q == CntMax);
      end
      StDiv: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CntW'(1);
        last  = fast_q || (cnt_q == CntMax);
      end
      default: state_d = StIdle;
    endcase
    if (last) begin
      state_d  = StFin;
      done_d   = 1'b1;
      result_d = sel_val;
    end
    if (flush && state_q != StIdle) begin
      state_d  = StIdle;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= OpMul;
      neg_p_q  <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      fast_q   <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_p_q  <= neg_p_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      fast_q   <= fast_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: iterative and single-cycle-multiply builds side by side.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, start_f = 1'b0, flush = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, busy_f, done_f;
  logic [31:0] result, result_f;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mdu_iter #(.XLEN(32), .FAST_MUL(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .result(result)
  );

  mdu_iter #(.XLEN(32), .FAST_MUL(1)) u_dut_fast (
    .clk(clk), .rst_n(rst_n), .start(start_f), .funct3(funct3), .a(a), .b(b),
    .flush(flush), .busy(busy_f), .done(done_f), .result(result_f)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at cycle 0 (just after an edge, unit idle); returns at cycle done+1.
  task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] exp, input int exp_cyc,
                       input bit use_fast);
    int cyc;
    bit seen;
    funct3 = f3;
    a      = av;
    b      = bv;
    if (use_fast) start_f = 1'b1;
    else start = 1'b1;
    step();
    start   = 1'b0;
    start_f = 1'b0;
    cyc     = 1;
    seen    = 1'b0;
    while (!seen && cyc < 100) begin
      if (use_fast ? done_f : done) seen = 1'b1;
      else begin
        step();
        cyc++;
      end
    end
    check_eq({tag, "/done_seen"}, 64'(seen), 64'd1);
    check_eq({tag, "/done_cycle"}, 64'(cyc), 64'(exp_cyc));
    check_eq({tag, "/result"}, 64'(use_fast ? result_f : result), 64'(exp));
    check_eq({tag, "/busy_with_done"}, 64'(use_fast ? busy_f : busy), 64'd1);
    step();
    check_eq({tag, "/busy_after"}, 64'(use_fast ? busy_f : busy), 64'd0);
    check_eq({tag, "/done_after"}, 64'(use_fast ? done_f : done), 64'd0);
  endtask

  initial begin
    int cyc;
    bit seen;

    #12;
    check_eq("reset/busy", 64'(busy), 64'd0);
    check_eq("reset/done", 64'(done), 64'd0);
    check_eq("reset/result", 64'(result), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    do_op("mul_7_m3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b0);
    do_op("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 1'b0);
    do_op("mulhu_ones", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0);
    do_op("mulhsu_ones", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1'b0);
    do_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0);
    do_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b0);
    do_op("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 33, 1'b0);
    do_op("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, 33, 1'b0);

    // Flush at cycle 10 of a divide
    funct3 = 3'b100;
    a      = 32'd1000;
    b      = 32'd3;
    start  = 1'b1;
    step();
    start  = 1'b0;
    repeat (9) step();
    check_eq("flush/busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("flush/busy_c11", 64'(busy), 64'd0);
    check_eq("flush/result_kept", 64'(result), 64'd2);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen = 1'b1;
      step();
    end
    check_eq("flush/no_done", 64'(seen), 64'd0);

    // start held high through the whole operation, operands changing underneath
    funct3 = 3'b101;
    a      = 32'd100;
    b      = 32'd7;
    start  = 1'b1;
    step();
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      if (done) begin
        seen  = 1'b1;
        start = 1'b0;
      end else begin
        a      = 32'hDEAD_0000 + 32'(cyc);
        b      = 32'd1;
        funct3 = 3'b000;
        step();
        cyc++;
      end
    end
    check_eq("held/done_cycle", 64'(cyc), 64'd33);
    check_eq("held/result", 64'(result), 64'd14);
    step();
    check_eq("held/busy_after", 64'(busy), 64'd0);

    // start and flush together in IDLE
    funct3 = 3'b101;
    a      = 32'd9;
    b      = 32'd3;
    start  = 1'b1;
    flush  = 1'b1;
    step();
    start  = 1'b0;
    flush  = 1'b0;
    check_eq("sf_idle/busy", 64'(busy), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) seen = 1'b1;
      step();
    end
    check_eq("sf_idle/nothing", 64'(seen), 64'd0);
    check_eq("sf_idle/result", 64'(result), 64'd14);

    do_op("div_5_0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, 1'b0);
    do_op("rem_5_0", 3'b110, 32'd5, 32'd0, 32'd5, 2, 1'b0);
    do_op("divu_0_0", 3'b101, 32'd0, 32'd0, 32'hFFFF_FFFF, 2, 1'b0);
    do_op("div_m5_0", 3'b100, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 2, 1'b0);
    do_op("rem_m5_0", 3'b110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 2, 1'b0);
    do_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 1'b0);
    do_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2, 1'b0);
    do_op("mulhu_pre_rst", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0);

    // Asynchronous reset at cycle 15 of a multiply
    funct3 = 3'b000;
    a      = 32'd7;
    b      = 32'hFFFF_FFFD;
    start  = 1'b1;
    step();
    start  = 1'b0;
    repeat (14) step();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst/busy", 64'(busy), 64'd0);
    check_eq("arst/done", 64'(done), 64'd0);
    check_eq("arst/result", 64'(result), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    do_op("mul_after_rst", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b0);

    do_op("fast_mul_7_m3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2, 1'b1);
    do_op("fast_mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2, 1'b1);
    do_op("fast_mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
